sig_ctrl: RTL

SIG_CTRL -- requirements
Module: sig_ctrl

---
 rtl/sig_ctrl_if.sv | 28 ++
 rtl/sig_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sig_ctrl_if.sv
// -----------------------------------------------------------------------------
// sig_ctrl_if -- configuration write channel of the sig_ctrl tone generator.
//
// Signals
//   cfg_valid  master -> slave  write request
//   cfg_ready  slave  -> master write can be accepted this cycle
//   cfg_ch     master -> slave  target channel 0..2 (3 is illegal)
//   cfg_half   master -> slave  new half-period in clk cycles
//   cfg_en     master -> slave  new channel enable
// A write is accepted on a posedge where cfg_valid & cfg_ready.
// -----------------------------------------------------------------------------
interface sig_ctrl_if;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_ch;
   logic [23:0] cfg_half;
   logic        cfg_en;

   modport master (
      output cfg_valid, cfg_ch, cfg_half, cfg_en,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_half, cfg_en,
      output cfg_ready
   );
endinterface

// File: rtl/sig_ctrl.sv
// -----------------------------------------------------------------------------
// sig_ctrl -- three phase-aligned square-wave generators with glitch-free,
// double-buffered reconfiguration.
//
// Each channel n counts 0..half and toggles sig_out[n] on the wrap, giving a
// period of 2*(half+1) clk cycles. New (half, en) values are written through
// the cfg interface into a one-entry shadow and applied only on the channel's
// wrap edge (or immediately when the channel is disabled or the block is idle),
// so a half-period is never cut short or stretched.
//
// Ports
//   clk      sole clock, rising edge
//   rst      asynchronous reset, active low
//   locked   clock-source lock; low holds all generators idle
//   run      high lets generators count; low holds them idle
//   cfg      sig_ctrl_if.slave configuration write channel
//   sig_out  square-wave outputs, bit n = channel n (idle level 1)
//   pend     bit n = channel n has a queued update in its shadow
//   cfg_err  sticky flag, set by an accepted write to channel 3
// -----------------------------------------------------------------------------
module sig_ctrl #(
   parameter logic [23:0] DEF_HALF0 = 24'h24C5D9,
   parameter logic [23:0] DEF_HALF1 = 24'h265831,
   parameter logic [23:0] DEF_HALF2 = 24'h27DED1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            locked,
   input  logic            run,
   sig_ctrl_if.slave       cfg,
   output logic [2:0]      sig_out,
   output logic [2:0]      pend,
   output logic            cfg_err
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   localparam logic [2:0][23:0] DEF_HALF = {DEF_HALF2, DEF_HALF1, DEF_HALF0};
   localparam logic [1:0]       CH_ILLEGAL = 2'd3;

   logic [0:0]  state;
   logic        active;
   logic        cfg_fire;
   logic [23:0] cfg_half_eff;

   assign active   = (state == ST_ACTIVE);
   assign cfg_fire = cfg.cfg_valid & cfg.cfg_ready;

   // A half-period of 0 would give a degenerate 2-cycle wave; clamp to 1.
   assign cfg_half_eff = (cfg.cfg_half == 24'd0) ? 24'd1 : cfg.cfg_half;

   // Writes to the illegal channel are always accepted so the master never
   // stalls on them; legal channels wait until their shadow is free.
   always_comb begin
      cfg.cfg_ready = 1'b1;
      case (cfg.cfg_ch)
         2'd0:    cfg.cfg_ready = locked & ~pend[0];
         2'd1:    cfg.cfg_ready = locked & ~pend[1];
         2'd2:    cfg.cfg_ready = locked & ~pend[2];
         default: cfg.cfg_ready = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= (locked & run) ? ST_ACTIVE : ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_err <= 1'b0;
      end else if (cfg_fire && cfg.cfg_ch == CH_ILLEGAL) begin
         cfg_err <= 1'b1;
      end
   end

   for (genvar n = 0; n < 3; n++) begin : g_ch
      logic [23:0] cnt;
      logic [23:0] half;
      logic [23:0] sh_half;
      logic        en;
      logic        sh_en;
      logic        out_q;
      logic        pend_q;
      logic        wr;
      logic        wrap;
      logic        apply;

      assign wr    = cfg_fire & (cfg.cfg_ch == 2'(n));
      assign wrap  = active & en & (cnt == half);
      // The shadow may only land where it cannot truncate a half-period.
      assign apply = pend_q & (~active | ~en | wrap);

      // NOTE: every register here, the shadow included, has a reset value so
      // a reset mid-write cannot leave a stale update behind.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt     <= '0;
            half    <= DEF_HALF[n];
            en      <= 1'b1;
            sh_half <= DEF_HALF[n];
            sh_en   <= 1'b1;
            out_q   <= 1'b1;
            pend_q  <= 1'b0;
         end else begin
            // wr and apply are exclusive: wr needs pend_q low, apply needs it high.
            if (wr) begin
               sh_half <= cfg_half_eff;
               sh_en   <= cfg.cfg_en;
               pend_q  <= 1'b1;
            end else if (apply) begin
               pend_q  <= 1'b0;
            end

            if (apply) begin
               half <= sh_half;
               en   <= sh_en;
            end

            // Idle, disabled, or being disabled now: park at counter 0, level 1.
            // A channel enabled from disabled also restarts from here.
            if (!active || !en || (apply && !sh_en)) begin
               cnt   <= '0;
               out_q <= 1'b1;
            end else if (wrap) begin
               cnt   <= '0;
               out_q <= ~out_q;
            end else begin
               cnt   <= cnt + 24'd1;
            end
         end
      end

      assign sig_out[n] = out_q;
      assign pend[n]    = pend_q;
   end

endmodule
